// File: rtl/toccata_audio_pkg.sv
// Shared Toccata audio definitions: attenuation-code constants, the 1.5 dB
// factor/threshold table and the level-meter FSM states.
package toccata_audio_pkg;

    localparam int ATTEN_LEVELS       = 64;
    localparam int FIXED_ATTEN_FACTOR = 27553;
    localparam int FIXED_ONE          = 32768;

    localparam int SAMPLE_W = 16;
    localparam int CODE_W   = 6;
    localparam int ITER_W   = 3;

    localparam logic [CODE_W-1:0]   CODE_LOUD   = 6'd0;
    localparam logic [CODE_W-1:0]   CODE_QUIET  = 6'd63;
    localparam logic [ITER_W-1:0]   SEARCH_LAST = 3'd5;
    localparam logic [SAMPLE_W-1:0] MAG_MAX     = 16'd32767;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEARCH_L = 2'd1,
        SEARCH_R = 2'd2,
        UPDATE   = 2'd3
    } meter_state_t;

    typedef logic [ATTEN_LEVELS-1:0][SAMPLE_W-1:0] thresh_table_t;

    // Q15 gain for an attenuation code; the volume block multiplies by this.
    function automatic int unsigned atten_factor(input int idx);
        int unsigned f;
        f = 32'(FIXED_ONE);
        for (int i = 1; i <= idx; i++) begin
            f = (f * 32'(FIXED_ATTEN_FACTOR)) >> 15;
        end
        return f;
    endfunction

    // Factor table clamped to the largest positive sample magnitude.
    function automatic thresh_table_t build_thresh_table();
        thresh_table_t t;
        int unsigned   f;
        f = 32'(FIXED_ONE);
        for (int i = 0; i < ATTEN_LEVELS; i++) begin
            t[i] = (f > 32'd32767) ? MAG_MAX : f[SAMPLE_W-1:0];
            f    = (f * 32'(FIXED_ATTEN_FACTOR)) >> 15;
        end
        return t;
    endfunction

    // -32768 has no positive twin, so it saturates to full scale.
    function automatic logic [SAMPLE_W-1:0] sat_mag(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] m;
        if (x == 16'sh8000) begin
            m = MAG_MAX;
        end else if (x[SAMPLE_W-1]) begin
            m = 16'(-x);
        end else begin
            m = 16'(x);
        end
        return m;
    endfunction

    function automatic logic is_clip(input logic signed [SAMPLE_W-1:0] x);
        return (x == 16'sh7FFF) || (x == 16'sh8000);
    endfunction

endpackage

// File: rtl/toccata_level_ballistics.sv
// Per-channel peak-hold and decay ballistics: displayed level, hold and
// decay counters, with synchronous clear taking priority over an update.
module toccata_level_ballistics
    import toccata_audio_pkg::*;
#(
    parameter int HOLD_SAMPLES  = 4800,
    parameter int DECAY_SAMPLES = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              update,
    input  logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] level
);

    localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam int DW = $clog2(DECAY_SAMPLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_SAMPLES);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_SAMPLES - 1);

    logic [CODE_W-1:0] level_q, level_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [DW-1:0]     decay_q, decay_d;

    // Next-state ballistics: a louder-or-equal code re-arms the hold.
    always_comb begin
        level_d = level_q;
        hold_d  = hold_q;
        decay_d = decay_q;
        if (clear) begin
            level_d = CODE_QUIET;
            hold_d  = {HW{1'b0}};
            decay_d = {DW{1'b0}};
        end else if (update) begin
            if (code <= level_q) begin
                level_d = code;
                hold_d  = HOLD_LOAD;
                decay_d = {DW{1'b0}};
            end else if (hold_q != {HW{1'b0}}) begin
                hold_d = hold_q - HW'(1'b1);
            end else if (decay_q == DECAY_LAST) begin
                decay_d = {DW{1'b0}};
                level_d = (level_q == CODE_QUIET) ? CODE_QUIET : level_q + 6'd1;
            end else begin
                decay_d = decay_q + DW'(1'b1);
            end
        end else begin
            level_d = level_q;
        end
    end

    // Ballistics state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= CODE_QUIET;
            hold_q  <= {HW{1'b0}};
            decay_q <= {DW{1'b0}};
        end else begin
            level_q <= level_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/toccata_level_meter.sv
// Stereo peak level meter: captures a sample pair, binary-searches each
// magnitude against the shared threshold table, then applies ballistics.
module toccata_level_meter
    import toccata_audio_pkg::*;
#(
    parameter int HOLD_SAMPLES  = 4800,
    parameter int DECAY_SAMPLES = 480
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic signed [SAMPLE_W-1:0] audio_in_left,
    input  logic signed [SAMPLE_W-1:0] audio_in_right,
    input  logic                       clear,
    output logic [CODE_W-1:0]          level_left,
    output logic [CODE_W-1:0]          level_right,
    output logic                       level_valid,
    output logic                       clip_left,
    output logic                       clip_right
);

    localparam thresh_table_t THRESH = build_thresh_table();

    meter_state_t        state_q, state_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic                update_s;
    logic                accept_s;
    logic                last_iter_s;

    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [CODE_W-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic [CODE_W-1:0]   code_l_q, code_l_d, code_r_q, code_r_d;
    logic [SAMPLE_W-1:0] mag_l_q, mag_l_d, mag_r_q, mag_r_d;
    logic                clip_l_q, clip_l_d, clip_r_q, clip_r_d;

    logic [SAMPLE_W-1:0] cur_mag_s;
    logic [CODE_W:0]     mid_sum_s;
    logic [CODE_W-1:0]   mid_s;
    logic                ge_s;
    logic [CODE_W-1:0]   lo_step_s, hi_step_s;

    assign accept_s    = sample_valid && ready_q;
    assign last_iter_s = (iter_q == SEARCH_LAST);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SEARCH_L;
                end else begin
                    state_d = IDLE;
                end
            end
            SEARCH_L: begin
                if (last_iter_s) begin
                    state_d = SEARCH_R;
                end else begin
                    state_d = SEARCH_L;
                end
            end
            SEARCH_R: begin
                if (last_iter_s) begin
                    state_d = UPDATE;
                end else begin
                    state_d = SEARCH_R;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; ready is registered from the upcoming state.
    always_comb begin
        ready_d  = (state_d == IDLE);
        valid_d  = (state_q == UPDATE);
        update_s = (state_q == UPDATE);
    end

    // One shared comparator step serves both channels in turn.
    always_comb begin
        cur_mag_s = (state_q == SEARCH_R) ? mag_r_q : mag_l_q;
        mid_sum_s = {1'b0, lo_q} + {1'b0, hi_q};
        mid_s     = 6'(mid_sum_s >> 1);
        ge_s      = (cur_mag_s >= THRESH[mid_s]);
        lo_step_s = ge_s ? lo_q : mid_s + 6'd1;
        hi_step_s = ge_s ? mid_s : hi_q;
    end

    // Search datapath: capture, iterate, latch each channel's code.
    always_comb begin
        iter_d   = iter_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        code_l_d = code_l_q;
        code_r_d = code_r_q;
        mag_l_d  = mag_l_q;
        mag_r_d  = mag_r_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    mag_l_d = sat_mag(audio_in_left);
                    mag_r_d = sat_mag(audio_in_right);
                    lo_d    = CODE_LOUD;
                    hi_d    = CODE_QUIET;
                    iter_d  = 3'd0;
                end else begin
                    iter_d = iter_q;
                end
            end
            SEARCH_L, SEARCH_R: begin
                if (last_iter_s) begin
                    lo_d   = CODE_LOUD;
                    hi_d   = CODE_QUIET;
                    iter_d = 3'd0;
                    if (state_q == SEARCH_L) begin
                        code_l_d = lo_step_s;
                    end else begin
                        code_r_d = lo_step_s;
                    end
                end else begin
                    lo_d   = lo_step_s;
                    hi_d   = hi_step_s;
                    iter_d = iter_q + 3'd1;
                end
            end
            default: begin
                iter_d = iter_q;
            end
        endcase
    end

    // Sticky clip flags; clear beats a clipping capture in the same cycle.
    always_comb begin
        clip_l_d = clip_l_q;
        clip_r_d = clip_r_q;
        if (clear) begin
            clip_l_d = 1'b0;
            clip_r_d = 1'b0;
        end else if (accept_s) begin
            clip_l_d = clip_l_q | is_clip(audio_in_left);
            clip_r_d = clip_r_q | is_clip(audio_in_right);
        end else begin
            clip_l_d = clip_l_q;
        end
    end

    // Datapath, handshake and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            iter_q   <= 3'd0;
            lo_q     <= CODE_LOUD;
            hi_q     <= CODE_QUIET;
            code_l_q <= CODE_QUIET;
            code_r_q <= CODE_QUIET;
            mag_l_q  <= 16'd0;
            mag_r_q  <= 16'd0;
            clip_l_q <= 1'b0;
            clip_r_q <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            iter_q   <= iter_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            code_l_q <= code_l_d;
            code_r_q <= code_r_d;
            mag_l_q  <= mag_l_d;
            mag_r_q  <= mag_r_d;
            clip_l_q <= clip_l_d;
            clip_r_q <= clip_r_d;
        end
    end

    toccata_level_ballistics #(
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .DECAY_SAMPLES(DECAY_SAMPLES)
    ) u_ball_left (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .update(update_s),
        .code  (code_l_q),
        .level (level_left)
    );

    toccata_level_ballistics #(
        .HOLD_SAMPLES (HOLD_SAMPLES),
        .DECAY_SAMPLES(DECAY_SAMPLES)
    ) u_ball_right (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .update(update_s),
        .code  (code_r_q),
        .level (level_right)
    );

    assign sample_ready = ready_q;
    assign level_valid  = valid_q;
    assign clip_left    = clip_l_q;
    assign clip_right   = clip_r_q;

endmodule
